id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Decode-to-execute pipeline stage of the 5-stage CPU. It drives the register-file read addresses, takes the read data, and resolves read-after-write hazards by forwarding from the MEM and WB stages. It detects load-use hazards and inserts bubbles when needed. Resolved operands and decoded control are latched into the ID/EX pipeline register, which feeds the ALU.

## Interface
Parameters:
- CTRL_W, 16: width of opaque ALU/branch control bundle passed through

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset; synchronous, active-high; clears all state
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt  in  5 each  source register numbers
- id_rs_used, id_rt_used  in  1 each  operand actually read
- id_dst  in  5  destination register
- id_we  in  1  instruction writes a register
- id_mem_read  in  1  instruction is a load
- id_imm, id_pc  in  32 each  extended immediate, PC
- id_ctrl  in  CTRL_W  control bundle
- rf_r1_addr, rf_r2_addr  out  5 each  register-file read addresses (= id_rs, id_rt)
- rf_r1_data, rf_r2_data  in  32 each  register-file read data, combinational
- mem_valid, mem_we, mem_is_load  in  1 each  MEM-stage instruction status
- mem_dst  in  5, mem_data  in  32  MEM-stage destination and ALU result
- wb_we  in  1, wb_dst  in  5, wb_data  in  32  same as register-file write port
- ex_stall  in  1  downstream cannot accept; hold the register
- flush  in  1  kill the ID and EX-stage instructions (branch redirect)
- id_stall  out  1  ID must hold; combinational
- ex_valid, ex_we, ex_mem_read  out  1 each
- ex_dst  out  5; ex_rs_val, ex_rt_val, ex_imm, ex_pc  out  32 each; ex_ctrl  out  CTRL_W
- bubble_cnt  out  32  count of hazard bubbles inserted

## Operation
- Match rule: source s matches writer X if s is used, s != 0, X is valid, X writes a register, and X dst == s.
- Operand select for each of rs and rt, in priority order:
  - s == 0 gives 0.
  - MEM match (not a load) gives mem_data.
  - WB match gives wb_data.
  - Otherwise the register-file data.
- The register file has no internal write-through, so the WB path is mandatory.
- Load-use hazard when id_valid and either:
  - the EX register (ex_valid, ex_we, ex_mem_read) matches rs or rt, or
  - MEM matches with mem_is_load.
- id_stall = !flush & (hazard | ex_stall).
- Register update priority:
  1. rst: all zero.
  2. flush: ex_valid = 0, ex_we = 0, ex_mem_read = 0.
  3. ex_stall: hold all fields.
  4. hazard: bubble, i.e. ex_valid = 0 and ex_we = 0, other fields don't-care.
  5. Otherwise load all id_* fields and the resolved operands; ex_valid = id_valid.
- bubble_cnt increments only on a step-4 cycle with id_valid = 1. It wraps modulo 2^32.

## Timing
- All ex_* outputs and bubble_cnt are registered, with 1-cycle latency from ID. Reset value of every one is 0.
- rf_r*_addr and id_stall are combinational from the current inputs.
- Load followed immediately by a dependent instruction: 2 bubble cycles, the first while the load is in EX and the second while it is in MEM. The operand then comes from WB.
- Load followed by the dependent instruction one slot later: 1 bubble.
- Simultaneous MEM and WB match: MEM wins, as the younger writer.
- ex_stall together with a hazard: hold, no bubble, no count.
- flush together with a hazard or ex_stall: flush wins, id_stall = 0, no count.
- Reset mid-stall: the next cycle has ex_valid = 0 and id_stall follows inputs only.

## Configuration
- ID_EX_FWD_EN defined: forwarding as described above.
- ID_EX_FWD_EN undefined: no MEM/WB muxing; operands always come from the register file (0 for $0).
  - Any match against the EX register, MEM, or WB counts as a hazard, regardless of load. The stage bubbles until no writer matches.
  - Priorities and bubble_cnt are unchanged.

## Test plan
- Reset: assert rst for 1 cycle; all ex_* = 0, bubble_cnt = 0, id_stall = 0.
- MEM forward: MEM dst=5, data=0x11; WB dst=5, data=0x22; ID rs=5. Next cycle ex_rs_val = 0x11, no bubble.
- Load-use: lw $8 in EX, then add using $8. id_stall high 2 cycles, 2 bubbles, bubble_cnt = 2. ex_rs_val equals the WB load data.
- $0: MEM dst=0 with we=1 and data=0xFFFF; ID rs=0. ex_rs_val = 0, no stall.
- Stall/flush: ex_stall for 3 cycles holds the EX fields unchanged. flush together with ex_stall gives ex_valid = 0 next cycle and id_stall = 0.
- Without ID_EX_FWD_EN: ALU write of $3 in EX followed by a reader of $3 gives 3 bubbles. The operand then comes from the register file once the write has landed.

Source files
------------

// File: rtl/id_ex_if.sv
// id_ex_if: bundle of every signal between the ID/EX stage and its surroundings
// (ID decode, register file, MEM/WB status, EX-side outputs).
//   master : the environment (decode, register file, later stages)
//   slave  : the id_ex_stage block
// Parameter CTRL_W sets the width of the opaque ALU/branch control bundle.
interface id_ex_if #(
    parameter int CTRL_W = 16
);
    // ID stage
    logic              id_valid;
    logic [4:0]        id_rs;
    logic [4:0]        id_rt;
    logic              id_rs_used;
    logic              id_rt_used;
    logic [4:0]        id_dst;
    logic              id_we;
    logic              id_mem_read;
    logic [31:0]       id_imm;
    logic [31:0]       id_pc;
    logic [CTRL_W-1:0] id_ctrl;
    // register file read ports
    logic [4:0]        rf_r1_addr;
    logic [4:0]        rf_r2_addr;
    logic [31:0]       rf_r1_data;
    logic [31:0]       rf_r2_data;
    // MEM and WB stage status
    logic              mem_valid;
    logic              mem_we;
    logic              mem_is_load;
    logic [4:0]        mem_dst;
    logic [31:0]       mem_data;
    logic              wb_we;
    logic [4:0]        wb_dst;
    logic [31:0]       wb_data;
    // pipeline control
    logic              ex_stall;
    logic              flush;
    logic              id_stall;
    // ID/EX register outputs
    logic              ex_valid;
    logic              ex_we;
    logic              ex_mem_read;
    logic [4:0]        ex_dst;
    logic [31:0]       ex_rs_val;
    logic [31:0]       ex_rt_val;
    logic [31:0]       ex_imm;
    logic [31:0]       ex_pc;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [31:0]       bubble_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_dst, id_we,
               id_mem_read, id_imm, id_pc, id_ctrl,
               rf_r1_data, rf_r2_data,
               mem_valid, mem_we, mem_is_load, mem_dst, mem_data,
               wb_we, wb_dst, wb_data, ex_stall, flush,
        input  rf_r1_addr, rf_r2_addr, id_stall,
               ex_valid, ex_we, ex_mem_read, ex_dst, ex_rs_val, ex_rt_val,
               ex_imm, ex_pc, ex_ctrl, bubble_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_dst, id_we,
               id_mem_read, id_imm, id_pc, id_ctrl,
               rf_r1_data, rf_r2_data,
               mem_valid, mem_we, mem_is_load, mem_dst, mem_data,
               wb_we, wb_dst, wb_data, ex_stall, flush,
        output rf_r1_addr, rf_r2_addr, id_stall,
               ex_valid, ex_we, ex_mem_read, ex_dst, ex_rs_val, ex_rt_val,
               ex_imm, ex_pc, ex_ctrl, bubble_cnt
    );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-to-execute pipeline stage.
// Drives register-file read addresses, resolves operands (with MEM/WB
// forwarding when enabled), detects hazards, inserts bubbles, and latches the
// ID/EX pipeline register.
// Ports:
//   clk  - clock, all state on rising edge
//   rst  - synchronous active-high reset, clears all state
//   bus  - id_ex_if.slave: ID inputs, register-file port, MEM/WB status,
//          ex_stall/flush, id_stall and all ex_* outputs, bubble_cnt
// Build option: define ID_EX_FWD_EN to enable MEM/WB operand forwarding.
// Without it operands always come from the register file and any pending
// writer of a source register stalls ID until the write has landed.
module id_ex_stage #(
    parameter int CTRL_W = 16
) (
    input  logic   clk,
    input  logic   rst,
    id_ex_if.slave bus
);

    logic              ex_valid_q, ex_valid_d;
    logic              ex_we_q, ex_we_d;
    logic              ex_mem_read_q, ex_mem_read_d;
    logic [4:0]        ex_dst_q, ex_dst_d;
    logic [31:0]       ex_rs_val_q, ex_rs_val_d;
    logic [31:0]       ex_rt_val_q, ex_rt_val_d;
    logic [31:0]       ex_imm_q, ex_imm_d;
    logic [31:0]       ex_pc_q, ex_pc_d;
    logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;
    logic [31:0]       bubble_cnt_q, bubble_cnt_d;

    logic              rs_ex, rt_ex, rs_mem, rt_mem, rs_wb, rt_wb;
    logic              hazard;
    logic [31:0]       rs_val, rt_val;

    function automatic logic src_match(input logic [4:0] s, input logic used,
                                       input logic v, input logic we,
                                       input logic [4:0] dst);
        return used && (s != 5'd0) && v && we && (dst == s);
    endfunction

    assign bus.rf_r1_addr = bus.id_rs;
    assign bus.rf_r2_addr = bus.id_rt;

    // WB has no separate valid; its write enable already implies a live writer.
    assign rs_mem = src_match(bus.id_rs, bus.id_rs_used, bus.mem_valid, bus.mem_we, bus.mem_dst);
    assign rt_mem = src_match(bus.id_rt, bus.id_rt_used, bus.mem_valid, bus.mem_we, bus.mem_dst);
    assign rs_wb  = src_match(bus.id_rs, bus.id_rs_used, bus.wb_we, bus.wb_we, bus.wb_dst);
    assign rt_wb  = src_match(bus.id_rt, bus.id_rt_used, bus.wb_we, bus.wb_we, bus.wb_dst);

`ifdef ID_EX_FWD_EN
    // Only a load in EX is a hazard; ALU results reach ID via MEM/WB later.
    assign rs_ex = src_match(bus.id_rs, bus.id_rs_used, ex_valid_q,
                             ex_we_q & ex_mem_read_q, ex_dst_q);
    assign rt_ex = src_match(bus.id_rt, bus.id_rt_used, ex_valid_q,
                             ex_we_q & ex_mem_read_q, ex_dst_q);
    assign hazard = bus.id_valid &
                    (rs_ex | rt_ex | ((rs_mem | rt_mem) & bus.mem_is_load));

    // MEM is the younger writer, so it takes priority over WB.
    always_comb begin
        rs_val = bus.rf_r1_data;
        if (bus.id_rs == 5'd0)             rs_val = 32'd0;
        else if (rs_mem && !bus.mem_is_load) rs_val = bus.mem_data;
        else if (rs_wb)                    rs_val = bus.wb_data;

        rt_val = bus.rf_r2_data;
        if (bus.id_rt == 5'd0)             rt_val = 32'd0;
        else if (rt_mem && !bus.mem_is_load) rt_val = bus.mem_data;
        else if (rt_wb)                    rt_val = bus.wb_data;
    end
`else
    // Any in-flight writer of a source blocks ID until it has retired.
    assign rs_ex = src_match(bus.id_rs, bus.id_rs_used, ex_valid_q, ex_we_q, ex_dst_q);
    assign rt_ex = src_match(bus.id_rt, bus.id_rt_used, ex_valid_q, ex_we_q, ex_dst_q);
    assign hazard = bus.id_valid &
                    (rs_ex | rt_ex | rs_mem | rt_mem | rs_wb | rt_wb);

    assign rs_val = (bus.id_rs == 5'd0) ? 32'd0 : bus.rf_r1_data;
    assign rt_val = (bus.id_rt == 5'd0) ? 32'd0 : bus.rf_r2_data;

    logic unused_fwd;
    assign unused_fwd = ^{bus.mem_data, bus.mem_is_load, bus.wb_data};
`endif

    assign bus.id_stall = !bus.flush & (hazard | bus.ex_stall);

    always_comb begin
        ex_valid_d    = ex_valid_q;
        ex_we_d       = ex_we_q;
        ex_mem_read_d = ex_mem_read_q;
        ex_dst_d      = ex_dst_q;
        ex_rs_val_d   = ex_rs_val_q;
        ex_rt_val_d   = ex_rt_val_q;
        ex_imm_d      = ex_imm_q;
        ex_pc_d       = ex_pc_q;
        ex_ctrl_d     = ex_ctrl_q;
        bubble_cnt_d  = bubble_cnt_q;
        if (bus.flush) begin
            ex_valid_d    = 1'b0;
            ex_we_d       = 1'b0;
            ex_mem_read_d = 1'b0;
        end else if (bus.ex_stall) begin
            // hold everything
        end else if (hazard) begin
            // bubble; data fields keep their old values
            ex_valid_d    = 1'b0;
            ex_we_d       = 1'b0;
            ex_mem_read_d = 1'b0;
            bubble_cnt_d  = bubble_cnt_q + 32'd1;
        end else begin
            ex_valid_d    = bus.id_valid;
            ex_we_d       = bus.id_we;
            ex_mem_read_d = bus.id_mem_read;
            ex_dst_d      = bus.id_dst;
            ex_rs_val_d   = rs_val;
            ex_rt_val_d   = rt_val;
            ex_imm_d      = bus.id_imm;
            ex_pc_d       = bus.id_pc;
            ex_ctrl_d     = bus.id_ctrl;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q    <= 1'b0;
            ex_we_q       <= 1'b0;
            ex_mem_read_q <= 1'b0;
            ex_dst_q      <= 5'd0;
            ex_rs_val_q   <= 32'd0;
            ex_rt_val_q   <= 32'd0;
            ex_imm_q      <= 32'd0;
            ex_pc_q       <= 32'd0;
            ex_ctrl_q     <= '0;
            bubble_cnt_q  <= 32'd0;
        end else begin
            ex_valid_q    <= ex_valid_d;
            ex_we_q       <= ex_we_d;
            ex_mem_read_q <= ex_mem_read_d;
            ex_dst_q      <= ex_dst_d;
            ex_rs_val_q   <= ex_rs_val_d;
            ex_rt_val_q   <= ex_rt_val_d;
            ex_imm_q      <= ex_imm_d;
            ex_pc_q       <= ex_pc_d;
            ex_ctrl_q     <= ex_ctrl_d;
            bubble_cnt_q  <= bubble_cnt_d;
        end
    end

    assign bus.ex_valid    = ex_valid_q;
    assign bus.ex_we       = ex_we_q;
    assign bus.ex_mem_read = ex_mem_read_q;
    assign bus.ex_dst      = ex_dst_q;
    assign bus.ex_rs_val   = ex_rs_val_q;
    assign bus.ex_rt_val   = ex_rt_val_q;
    assign bus.ex_imm      = ex_imm_q;
    assign bus.ex_pc       = ex_pc_q;
    assign bus.ex_ctrl     = ex_ctrl_q;
    assign bus.bubble_cnt  = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model of the
// ID/EX register. Follows ID_EX_FWD_EN the same way the design does.
module tb_id_ex_stage;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    id_ex_if #(.CTRL_W(16)) bus ();

    id_ex_stage #(.CTRL_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // behavioural model of the ID/EX register contents
    bit          m_valid, m_we, m_mr, m_known;
    logic [4:0]  m_dst;
    logic [31:0] m_rs, m_rt, m_imm, m_pc, m_cnt;
    logic [15:0] m_ctrl;
    bit          last_stall;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit writes(input logic [4:0] s, input logic u, input logic v,
                                  input logic w, input logic [4:0] d);
        return u && s != 5'd0 && v && w && d == s;
    endfunction

    function automatic bit model_hazard();
        bit ex_hit, mem_hit, wb_hit;
`ifdef ID_EX_FWD_EN
        ex_hit = writes(bus.id_rs, bus.id_rs_used, m_valid, m_we && m_mr, m_dst) ||
                 writes(bus.id_rt, bus.id_rt_used, m_valid, m_we && m_mr, m_dst);
        mem_hit = bus.mem_is_load &&
                  (writes(bus.id_rs, bus.id_rs_used, bus.mem_valid, bus.mem_we, bus.mem_dst) ||
                   writes(bus.id_rt, bus.id_rt_used, bus.mem_valid, bus.mem_we, bus.mem_dst));
        wb_hit = 1'b0;
`else
        ex_hit = writes(bus.id_rs, bus.id_rs_used, m_valid, m_we, m_dst) ||
                 writes(bus.id_rt, bus.id_rt_used, m_valid, m_we, m_dst);
        mem_hit = writes(bus.id_rs, bus.id_rs_used, bus.mem_valid, bus.mem_we, bus.mem_dst) ||
                  writes(bus.id_rt, bus.id_rt_used, bus.mem_valid, bus.mem_we, bus.mem_dst);
        wb_hit = writes(bus.id_rs, bus.id_rs_used, bus.wb_we, bus.wb_we, bus.wb_dst) ||
                 writes(bus.id_rt, bus.id_rt_used, bus.wb_we, bus.wb_we, bus.wb_dst);
`endif
        return bus.id_valid && (ex_hit || mem_hit || wb_hit);
    endfunction

    function automatic logic [31:0] operand(input logic [4:0] s, input logic u,
                                            input logic [31:0] rf);
        if (s == 5'd0) return 32'd0;
`ifdef ID_EX_FWD_EN
        if (writes(s, u, bus.mem_valid, bus.mem_we, bus.mem_dst) && !bus.mem_is_load)
            return bus.mem_data;
        if (writes(s, u, bus.wb_we, bus.wb_we, bus.wb_dst)) return bus.wb_data;
`endif
        return rf;
    endfunction

    task automatic compare_regs();
        check("ex_valid", 32'(bus.ex_valid), 32'(m_valid));
        check("ex_we", 32'(bus.ex_we), 32'(m_we));
        check("bubble_cnt", bus.bubble_cnt, m_cnt);
        if (m_known) begin
            check("ex_mem_read", 32'(bus.ex_mem_read), 32'(m_mr));
            check("ex_dst", 32'(bus.ex_dst), 32'(m_dst));
            check("ex_rs_val", bus.ex_rs_val, m_rs);
            check("ex_rt_val", bus.ex_rt_val, m_rt);
            check("ex_imm", bus.ex_imm, m_imm);
            check("ex_pc", bus.ex_pc, m_pc);
            check("ex_ctrl", 32'(bus.ex_ctrl), 32'(m_ctrl));
        end
    endtask

    // One cycle: inputs were set at the falling edge.
    task automatic step();
        bit haz, exp_stall;
        logic [31:0] a, b;
        #1;
        haz = model_hazard();
        exp_stall = !bus.flush && (haz || bus.ex_stall);
        last_stall = bus.id_stall;
        check("id_stall", 32'(bus.id_stall), 32'(exp_stall));
        check("rf_r1_addr", 32'(bus.rf_r1_addr), 32'(bus.id_rs));
        check("rf_r2_addr", 32'(bus.rf_r2_addr), 32'(bus.id_rt));
        a = operand(bus.id_rs, bus.id_rs_used, bus.rf_r1_data);
        b = operand(bus.id_rt, bus.id_rt_used, bus.rf_r2_data);
        @(posedge clk);
        if (rst) begin
            {m_valid, m_we, m_mr} = 3'b000;
            m_dst = '0; m_rs = '0; m_rt = '0; m_imm = '0; m_pc = '0; m_ctrl = '0;
            m_cnt = '0; m_known = 1'b1;
        end else if (bus.flush) begin
            {m_valid, m_we, m_mr} = 3'b000;
            m_known = 1'b0;
        end else if (bus.ex_stall) begin
        end else if (haz) begin
            m_valid = 1'b0; m_we = 1'b0; m_known = 1'b0;
            m_cnt = m_cnt + 32'd1;
        end else begin
            m_valid = bus.id_valid; m_we = bus.id_we; m_mr = bus.id_mem_read;
            m_dst = bus.id_dst; m_rs = a; m_rt = b;
            m_imm = bus.id_imm; m_pc = bus.id_pc; m_ctrl = bus.id_ctrl;
            m_known = 1'b1;
        end
        #1;
        compare_regs();
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 1'b0;
        bus.id_valid = 0; bus.id_rs = 0; bus.id_rt = 0; bus.id_rs_used = 0; bus.id_rt_used = 0;
        bus.id_dst = 0; bus.id_we = 0; bus.id_mem_read = 0; bus.id_imm = 0; bus.id_pc = 0;
        bus.id_ctrl = 0; bus.rf_r1_data = 0; bus.rf_r2_data = 0;
        bus.mem_valid = 0; bus.mem_we = 0; bus.mem_is_load = 0; bus.mem_dst = 0; bus.mem_data = 0;
        bus.wb_we = 0; bus.wb_dst = 0; bus.wb_data = 0; bus.ex_stall = 0; bus.flush = 0;
    endtask

    task automatic randomize_inputs();
        rst = ($urandom_range(0, 63) == 0);
        bus.id_valid = ($urandom_range(0, 3) != 0);
        bus.id_rs = 5'($urandom_range(0, 3));
        bus.id_rt = 5'($urandom_range(0, 3));
        bus.id_rs_used = 1'($urandom_range(0, 1));
        bus.id_rt_used = 1'($urandom_range(0, 1));
        bus.id_dst = 5'($urandom_range(0, 3));
        bus.id_we = 1'($urandom_range(0, 1));
        bus.id_mem_read = 1'($urandom_range(0, 1));
        bus.id_imm = $urandom; bus.id_pc = $urandom; bus.id_ctrl = 16'($urandom);
        bus.rf_r1_data = $urandom; bus.rf_r2_data = $urandom;
        bus.mem_valid = 1'($urandom_range(0, 1));
        bus.mem_we = 1'($urandom_range(0, 1));
        bus.mem_is_load = 1'($urandom_range(0, 1));
        bus.mem_dst = 5'($urandom_range(0, 3));
        bus.mem_data = $urandom;
        bus.wb_we = 1'($urandom_range(0, 1));
        bus.wb_dst = 5'($urandom_range(0, 3));
        bus.wb_data = $urandom;
        bus.ex_stall = ($urandom_range(0, 4) == 0);
        bus.flush = ($urandom_range(0, 9) == 0);
    endtask

    initial begin
        logic [31:0] cnt0;
        idle();
        rst = 1'b1;
        @(negedge clk);
        step();
        check("reset ex_valid", 32'(bus.ex_valid), 32'd0);
        check("reset ex_rs_val", bus.ex_rs_val, 32'd0);
        check("reset ex_ctrl", 32'(bus.ex_ctrl), 32'd0);
        check("reset bubble_cnt", bus.bubble_cnt, 32'd0);
        rst = 1'b0;
        #1;
        check("reset id_stall", 32'(bus.id_stall), 32'd0);

`ifdef ID_EX_FWD_EN
        // MEM beats WB for the same register
        idle();
        bus.mem_valid = 1; bus.mem_we = 1; bus.mem_dst = 5; bus.mem_data = 32'h11;
        bus.wb_we = 1; bus.wb_dst = 5; bus.wb_data = 32'h22;
        bus.id_valid = 1; bus.id_rs = 5; bus.id_rs_used = 1; bus.rf_r1_data = 32'h99;
        step();
        check("memfwd stall", 32'(last_stall), 32'd0);
        check("memfwd ex_rs_val", bus.ex_rs_val, 32'h11);
        check("memfwd bubbles", bus.bubble_cnt, 32'd0);

        // load-use back to back: two bubbles, operand from WB
        cnt0 = bus.bubble_cnt;
        idle();
        bus.id_valid = 1; bus.id_dst = 8; bus.id_we = 1; bus.id_mem_read = 1;
        step();
        idle();
        bus.id_valid = 1; bus.id_rs = 8; bus.id_rs_used = 1; bus.rf_r1_data = 32'h5;
        step();
        check("lu stall1", 32'(last_stall), 32'd1);
        bus.mem_valid = 1; bus.mem_we = 1; bus.mem_is_load = 1; bus.mem_dst = 8;
        step();
        check("lu stall2", 32'(last_stall), 32'd1);
        bus.mem_valid = 0; bus.mem_we = 0; bus.mem_is_load = 0;
        bus.wb_we = 1; bus.wb_dst = 8; bus.wb_data = 32'h77;
        step();
        check("lu stall3", 32'(last_stall), 32'd0);
        check("lu ex_rs_val", bus.ex_rs_val, 32'h77);
        check("lu bubbles", bus.bubble_cnt, cnt0 + 32'd2);
`else
        // ALU writer of $3 then a reader: three bubbles, operand from the RF
        idle();
        bus.id_valid = 1; bus.id_dst = 3; bus.id_we = 1;
        step();
        idle();
        bus.id_valid = 1; bus.id_rs = 3; bus.id_rs_used = 1; bus.id_dst = 4;
        bus.rf_r1_data = 32'hDEAD;
        step();
        check("nofwd stall1", 32'(last_stall), 32'd1);
        bus.mem_valid = 1; bus.mem_we = 1; bus.mem_dst = 3; bus.mem_data = 32'h33;
        step();
        check("nofwd stall2", 32'(last_stall), 32'd1);
        bus.mem_valid = 0; bus.mem_we = 0;
        bus.wb_we = 1; bus.wb_dst = 3; bus.wb_data = 32'h33;
        step();
        check("nofwd stall3", 32'(last_stall), 32'd1);
        bus.wb_we = 0; bus.rf_r1_data = 32'h33;
        step();
        check("nofwd stall4", 32'(last_stall), 32'd0);
        check("nofwd ex_rs_val", bus.ex_rs_val, 32'h33);
        check("nofwd bubbles", bus.bubble_cnt, 32'd3);
        cnt0 = bus.bubble_cnt;
`endif

        // $0 never forwards and never stalls
        idle();
        bus.mem_valid = 1; bus.mem_we = 1; bus.mem_dst = 0; bus.mem_data = 32'hFFFF;
        bus.id_valid = 1; bus.id_rs = 0; bus.id_rs_used = 1; bus.rf_r1_data = 32'h1234;
        step();
        check("r0 stall", 32'(last_stall), 32'd0);
        check("r0 ex_rs_val", bus.ex_rs_val, 32'd0);

        // ex_stall holds for three cycles, then flush beats ex_stall
        idle();
        bus.id_valid = 1; bus.id_rs = 1; bus.id_rs_used = 1; bus.rf_r1_data = 32'h1111;
        bus.id_dst = 6; bus.id_we = 1; bus.id_imm = 32'hAAAA; bus.id_pc = 32'h100;
        bus.id_ctrl = 16'h5A5A;
        step();
        bus.ex_stall = 1; bus.id_imm = 32'hBBBB; bus.id_pc = 32'h200;
        bus.id_ctrl = 16'h1234; bus.rf_r1_data = 32'h2222;
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold stall", 32'(last_stall), 32'd1);
        end
        check("hold ex_imm", bus.ex_imm, 32'hAAAA);
        check("hold ex_pc", bus.ex_pc, 32'h100);
        check("hold ex_rs_val", bus.ex_rs_val, 32'h1111);
        check("hold ex_ctrl", 32'(bus.ex_ctrl), 32'h5A5A);
        check("hold ex_valid", 32'(bus.ex_valid), 32'd1);
        cnt0 = bus.bubble_cnt;
        bus.flush = 1;
        step();
        check("flush stall", 32'(last_stall), 32'd0);
        check("flush ex_valid", 32'(bus.ex_valid), 32'd0);
        check("flush bubbles", bus.bubble_cnt, cnt0);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            randomize_inputs();
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
